pc_sequencer: RTL

- Control sequencer for the 64-bit program counter datapath; drives its enable and 2-bit next-PC select.
- Arbitrates among sequential fetch, immediate-offset branch, register branch (BR), hazard stall and halt.
- Serialises redirects against a non-abortable instruction-memory fetch handshake.
- Sits between the hazard/branch-resolution logic and the PC + instruction memory in the CPU top level.

---
 rtl/pc_seq_pkg.sv | 23 ++
 rtl/pc_sequencer_sat_counter.sv | 23 ++
 rtl/pc_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the program-counter sequencer.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      S_BOOT  = 2'b00,
      S_FETCH = 2'b01,
      S_DRAIN = 2'b10,
      S_HALT  = 2'b11
   } state_t;

   localparam logic [1:0] PCSRC_SEQ  = 2'b00;
   localparam logic [1:0] PCSRC_IMM  = 2'b01;
   localparam logic [1:0] PCSRC_REG  = 2'b10;
   localparam logic [1:0] PCSRC_HOLD = 2'b11;

   localparam logic BRK_IMM = 1'b0;
   localparam logic BRK_REG = 1'b1;

   function automatic logic [1:0] kind_to_src(input logic kind);
      return (kind == BRK_REG) ? PCSRC_REG : PCSRC_IMM;
   endfunction

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating event counter with enable; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_en,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_en && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// PC enable / next-PC select sequencer serialising redirects against a non-abortable fetch.
// Optional performance counters are built when PC_SEQ_PERF_EN is defined.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int BOOT_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             imem_ready,
   input  logic             stall,
   input  logic             br_valid,
   input  logic             br_kind,
   input  logic             halt_req,
   output logic             pc_en,
   output logic [1:0]       pc_src,
   output logic             imem_req,
   output logic             flush,
   output logic             halted
`ifdef PC_SEQ_PERF_EN
   ,
   output logic [CNT_W-1:0] redirect_cnt,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   state_t     r_state;
   logic [3:0] r_boot_cnt;
   logic       r_pend_valid;
   logic       r_pend_kind;
   logic       r_halt_pend;

   state_t     w_state_next;
   logic [3:0] w_boot_cnt_next;
   logic       w_pend_valid_next;
   logic       w_pend_kind_next;
   logic       w_halt_pend_next;
   logic [1:0] w_src;
   logic       w_halt_now;
   logic       w_eff_valid;
   logic       w_eff_kind;

   always_comb begin
      w_state_next      = r_state;
      w_boot_cnt_next   = r_boot_cnt;
      w_pend_valid_next = r_pend_valid;
      w_pend_kind_next  = r_pend_kind;
      w_halt_pend_next  = r_halt_pend;
      w_src             = PCSRC_HOLD;
      w_halt_now        = r_halt_pend | halt_req;
      w_eff_valid       = r_pend_valid;
      w_eff_kind        = r_pend_kind;
      pc_en             = 1'b0;
      imem_req          = 1'b0;
      flush             = 1'b0;
      halted            = 1'b0;

      case (r_state)
         S_BOOT: begin
            if (halt_req) begin
               w_state_next = S_HALT;
            end else if (r_boot_cnt == 4'(BOOT_CYCLES - 1)) begin
               w_state_next = S_FETCH;
            end else begin
               w_boot_cnt_next = r_boot_cnt + 4'd1;
            end
         end

         S_FETCH: begin
            imem_req = 1'b1;
            if (halt_req) begin
               if (imem_ready) begin
                  w_state_next = S_HALT;
               end else begin
                  w_state_next     = S_DRAIN;
                  w_halt_pend_next = 1'b1;
               end
            end else if (br_valid) begin
               if (imem_ready) begin
                  pc_en = 1'b1;
                  w_src = kind_to_src(br_kind);
                  flush = 1'b1;
               end else begin
                  w_pend_valid_next = 1'b1;
                  w_pend_kind_next  = br_kind;
                  w_state_next      = S_DRAIN;
               end
            end else if (!stall && imem_ready) begin
               pc_en = 1'b1;
               w_src = PCSRC_SEQ;
            end
         end

         S_DRAIN: begin
            imem_req = 1'b1;
            // Youngest redirect wins, but once a halt is known no new redirect is accepted.
            if (br_valid && !w_halt_now) begin
               w_eff_valid = 1'b1;
               w_eff_kind  = br_kind;
            end
            if (imem_ready) begin
               if (w_eff_valid) begin
                  pc_en = 1'b1;
                  w_src = kind_to_src(w_eff_kind);
                  flush = 1'b1;
               end
               w_pend_valid_next = 1'b0;
               w_halt_pend_next  = 1'b0;
               w_state_next      = w_halt_now ? S_HALT : S_FETCH;
            end else begin
               w_pend_valid_next = w_eff_valid;
               w_pend_kind_next  = w_eff_kind;
               w_halt_pend_next  = w_halt_now;
            end
         end

         S_HALT: begin
            halted = 1'b1;
         end

         default: begin
            w_state_next = S_BOOT;
         end
      endcase
   end

   assign pc_src = pc_en ? w_src : PCSRC_HOLD;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_BOOT;
         r_boot_cnt   <= 4'd0;
         r_pend_valid <= 1'b0;
         r_pend_kind  <= BRK_IMM;
         r_halt_pend  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_boot_cnt   <= w_boot_cnt_next;
         r_pend_valid <= w_pend_valid_next;
         r_pend_kind  <= w_pend_kind_next;
         r_halt_pend  <= w_halt_pend_next;
      end
   end

`ifdef PC_SEQ_PERF_EN
   logic w_stall_ev;

   assign w_stall_ev = (r_state == S_FETCH) && stall && !br_valid;

   sat_counter #(.W(CNT_W)) u_redirect_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_en    (flush),
      .o_count (redirect_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_stall_ev),
      .o_count (stall_cnt)
   );
`endif

endmodule
